// File: rtl/cic_comp_fir.sv
// cic_comp_fir: serial-MAC FIR behind the CIC decimator.
// Each accepted sample is written into a circular delay line. The block then
// runs one multiply-accumulate per clock over all taps, and finally produces a
// rounded, saturated output with a single-cycle y_valid pulse.
// After reset the coefficient set is a unity passthrough.
module cic_comp_fir #(
  parameter int TAPS    = 8,
  parameter int X_WIDTH = 12,
  parameter int C_WIDTH = 12,
  parameter int Y_WIDTH = 12,
  parameter int SHIFT   = C_WIDTH - 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enabled,
  input  logic signed [X_WIDTH-1:0]   x,
  input  logic                        x_valid,
  input  logic                        coef_we,
  input  logic [$clog2(TAPS)-1:0]     coef_addr,
  input  logic signed [C_WIDTH-1:0]   coef_data,
  output logic signed [Y_WIDTH-1:0]   y,
  output logic                        y_valid,
  output logic                        busy,
  output logic                        overrun
);

  localparam int PW        = $clog2(TAPS);
  localparam int P_WIDTH   = X_WIDTH + C_WIDTH;
  localparam int ACC_WIDTH = X_WIDTH + C_WIDTH + $clog2(TAPS);

  // Rounding offset and output limits, widened by one bit so the
  // round-half-up addition can never wrap.
  localparam logic signed [ACC_WIDTH:0] HALF  = (ACC_WIDTH+1)'(1) <<< (SHIFT-1);
  localparam logic signed [ACC_WIDTH:0] Y_MAX = (ACC_WIDTH+1)'(2**(Y_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH:0] Y_MIN = (ACC_WIDTH+1)'(-(2**(Y_WIDTH-1)));

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                      state, state_nxt;
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               k;
  logic [PW-1:0]               rd_ptr;
  logic signed [X_WIDTH-1:0]   delay [TAPS];
  logic signed [C_WIDTH-1:0]   coef  [TAPS];
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [P_WIDTH-1:0]   prod;
  logic                        accept;
  logic                        last_tap;

  // y = sat((acc + 2^(SHIFT-1)) >>> SHIFT), i.e. round half up, then clamp.
  function automatic logic signed [Y_WIDTH-1:0] round_sat(
    input logic signed [ACC_WIDTH-1:0] a
  );
    logic signed [ACC_WIDTH:0] sum;
    logic signed [ACC_WIDTH:0] q;
    sum = (ACC_WIDTH+1)'(a) + HALF;
    q   = sum >>> SHIFT;
    if (q > Y_MAX)      return Y_WIDTH'(Y_MAX);
    else if (q < Y_MIN) return Y_WIDTH'(Y_MIN);
    else                return Y_WIDTH'(q);
  endfunction

  assign busy     = (state != S_IDLE);
  assign accept   = (state == S_IDLE) && x_valid && enabled;
  assign last_tap = (k == PW'(TAPS-1));

  // Tap k reads the sample k positions older than the newest one.
  always_comb begin
    rd_ptr = '0;
    if (wr_ptr >= k) rd_ptr = wr_ptr - k;
    else             rd_ptr = PW'({1'b0, wr_ptr} + (PW+1)'(TAPS) - {1'b0, k});
  end

  // Full-precision product of the current tap.
  always_comb begin
    prod = P_WIDTH'(coef[k]) * P_WIDTH'(delay[rd_ptr]);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE -> MAC (TAPS clocks) -> OUT -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)   state_nxt = S_MAC;
      S_MAC:   if (last_tap) state_nxt = S_OUT;
      S_OUT:                 state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  // Datapath: sample capture, coefficient writes, accumulation and output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        delay[i] <= '0;
        coef[i]  <= (i == 0) ? C_WIDTH'(2**SHIFT) : '0;
      end
      acc     <= '0;
      k       <= '0;
      wr_ptr  <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (x_valid && enabled && busy) overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            delay[wr_ptr] <= x;
            acc           <= '0;
            k             <= '0;
          end else if (coef_we && (32'(coef_addr) < TAPS)) begin
            coef[coef_addr] <= coef_data;
          end
        end
        S_MAC: begin
          acc <= acc + ACC_WIDTH'(prod);
          k   <= k + PW'(1);
        end
        S_OUT: begin
          y       <= round_sat(acc);
          y_valid <= 1'b1;
          wr_ptr  <= (wr_ptr == PW'(TAPS-1)) ? '0 : wr_ptr + PW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Testbench for cic_comp_fir: directed and random samples checked against an
// age-indexed convolution model with round-half-up and saturation.
module tb_cic_comp_fir;

  localparam int TAPS  = 8;
  localparam int SHIFT = 10;
  localparam int Y_MAX = 2047;
  localparam int Y_MIN = -2048;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enabled;
  logic signed [11:0] x;
  logic               x_valid;
  logic               coef_we;
  logic [2:0]         coef_addr;
  logic signed [11:0] coef_data;
  logic signed [11:0] y;
  logic               y_valid;
  logic               busy;
  logic               overrun;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: coefficients and the sample history, index = age.
  int coefm [TAPS];
  int hist  [TAPS];

  cic_comp_fir dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enabled   (enabled),
    .x         (x),
    .x_valid   (x_valid),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .y         (y),
    .y_valid   (y_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin
      hist[i]  = 0;
      coefm[i] = 0;
    end
    coefm[0] = 1 << SHIFT;
  endfunction

  function automatic void model_push(input int v);
    for (int i = TAPS-1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = v;
  endfunction

  function automatic int model_y();
    longint acc = 0;
    longint r;
    for (int i = 0; i < TAPS; i++) acc += longint'(coefm[i]) * longint'(hist[i]);
    r = (acc + (longint'(1) <<< (SHIFT-1))) >>> SHIFT;
    if (r > Y_MAX) return Y_MAX;
    if (r < Y_MIN) return Y_MIN;
    return int'(r);
  endfunction

  task automatic write_coef(input int a, input int d, input bit upd);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 3'(a); coef_data = 12'(d);
    @(negedge clk);
    coef_we = 1'b0;
    if (upd) coefm[a] = d;
  endtask

  // Wait (bounded) for y_valid, checking latency, value and pulse width.
  task automatic wait_result(input string tag, input int exp, input int exp_lat,
                             output int yo);
    bit got = 1'b0;
    int lat = 0;
    yo = 0;
    for (int i = 0; i < TAPS + 10; i++) begin
      if (y_valid) begin got = 1'b1; lat = i; yo = int'(y); break; end
      @(negedge clk);
    end
    check({tag, " done"}, int'(got), 1);
    if (got) begin
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " y"}, yo, exp);
      @(negedge clk);
      check({tag, " pulse"}, int'(y_valid), 0);
    end
  endtask

  task automatic run_sample(input int xv, input string tag, output int yo);
    int exp;
    model_push(xv);
    exp = model_y();
    @(negedge clk);
    x = 12'(xv); x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    wait_result(tag, exp, TAPS + 1, yo);
  endtask

  task automatic count_pulses(input int cycles, output int cnt, output int ylast);
    cnt = 0; ylast = 0;
    for (int i = 0; i < cycles; i++) begin
      if (y_valid) begin cnt++; ylast = int'(y); end
      @(negedge clk);
    end
  endtask

  initial begin
    int yo, cnt, exp, v;
    rst_n = 1'b0; enabled = 1'b1; x = '0; x_valid = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    check("rst y", int'(y), 0);
    check("rst y_valid", int'(y_valid), 0);
    check("rst busy", int'(busy), 0);
    check("rst overrun", int'(overrun), 0);

    // enabled low: strobe ignored, no overrun.
    enabled = 1'b0;
    @(negedge clk); x = 12'(123); x_valid = 1'b1;
    @(negedge clk); x_valid = 1'b0;
    count_pulses(15, cnt, yo);
    check("disabled pulses", cnt, 0);
    check("disabled overrun", int'(overrun), 0);
    enabled = 1'b1;

    // Post-reset passthrough.
    run_sample(100, "pass100", yo);
    check("pass100 const", yo, 100);
    run_sample(-77, "pass-77", yo);
    check("pass-77 const", yo, -77);

    // Boxcar of 1024s: flush history, then impulse.
    for (int i = 0; i < TAPS; i++) write_coef(i, 1024, 1'b1);
    for (int i = 0; i < TAPS; i++) run_sample(0, $sformatf("flush%0d", i), yo);
    run_sample(100, "imp0", yo);
    check("imp0 const", yo, 100);
    for (int i = 1; i < TAPS; i++) begin
      run_sample(0, $sformatf("imp%0d", i), yo);
      check($sformatf("imp%0d const", i), yo, 100);
    end
    run_sample(0, "imp_end", yo);
    check("imp_end const", yo, 0);

    // Rounding with a half-gain single tap.
    write_coef(0, 512, 1'b1);
    for (int i = 1; i < TAPS; i++) write_coef(i, 0, 1'b1);
    run_sample(3, "rnd+3", yo);   check("rnd+3 const", yo, 2);
    run_sample(-3, "rnd-3", yo);  check("rnd-3 const", yo, -1);
    run_sample(4, "rnd+4", yo);   check("rnd+4 const", yo, 2);

    // Saturation at both rails.
    for (int i = 0; i < TAPS; i++) write_coef(i, 2047, 1'b1);
    for (int i = 0; i < TAPS; i++) run_sample(2047, $sformatf("satp%0d", i), yo);
    check("satp const", yo, 2047);
    for (int i = 0; i < TAPS; i++) run_sample(-2048, $sformatf("satn%0d", i), yo);
    check("satn const", yo, -2048);

    // Random coefficients and samples.
    for (int i = 0; i < TAPS; i++) write_coef(i, int'($urandom_range(1200)) - 600, 1'b1);
    for (int i = 0; i < 24; i++)
      run_sample(int'($urandom_range(4095)) - 2048, $sformatf("rand%0d", i), yo);

    // Strobe during OUT is dropped; strobe the following cycle is accepted.
    model_push(311); exp = model_y();
    @(negedge clk); x = 12'(311); x_valid = 1'b1;
    @(negedge clk); x_valid = 1'b0;
    repeat (TAPS) @(negedge clk);
    x = 12'(-999); x_valid = 1'b1;
    @(negedge clk);
    check("outdrop y_valid", int'(y_valid), 1);
    check("outdrop y", int'(y), exp);
    x = 12'(-455);
    @(negedge clk); x_valid = 1'b0;
    model_push(-455); exp = model_y();
    wait_result("afterout", exp, TAPS + 1, yo);
    check("afterout overrun", int'(overrun), 1);

    // Overrun: back-to-back strobes after a fresh reset.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    check("ovr pre", int'(overrun), 0);
    model_push(600); exp = model_y();
    @(negedge clk); x = 12'(600); x_valid = 1'b1;
    @(negedge clk); x = 12'(-321);
    @(negedge clk); x_valid = 1'b0;
    check("ovr busy", int'(busy), 1);
    count_pulses(TAPS + 10, cnt, yo);
    check("ovr pulses", cnt, 1);
    check("ovr y", yo, exp);
    check("ovr sticky", int'(overrun), 1);
    run_sample(25, "ovr next", yo);
    check("ovr held", int'(overrun), 1);

    // Coefficient write while busy is ignored.
    @(negedge clk); x = 12'(200); x_valid = 1'b1;
    @(negedge clk); x_valid = 1'b0;
    model_push(200); exp = model_y();
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = 12'(-1000);
    @(negedge clk); coef_we = 1'b0;
    wait_result("cwbusy", exp, TAPS, yo);
    // Coefficient write on the accepting edge is ignored.
    @(negedge clk); x = 12'(-150); x_valid = 1'b1;
    coef_we = 1'b1; coef_addr = 3'd1; coef_data = 12'(700);
    @(negedge clk); x_valid = 1'b0; coef_we = 1'b0;
    model_push(-150); exp = model_y();
    wait_result("cwaccept", exp, TAPS + 1, yo);
    run_sample(80, "cwafter", yo);

    // Reset mid-MAC aborts the computation.
    @(negedge clk); x = 12'(77); x_valid = 1'b1;
    @(negedge clk); x_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst busy", int'(busy), 0);
    check("midrst y", int'(y), 0);
    check("midrst overrun", int'(overrun), 0);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    count_pulses(TAPS + 10, cnt, yo);
    check("midrst pulses", cnt, 0);
    check("midrst y_valid", int'(y_valid), 0);
    run_sample(50, "post rst", yo);
    check("post rst const", yo, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
